data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory stage downstream of the pipelined RISC-V core's MEM stage. Consumes MemWrite/DataAdr/WriteData,
//  performs byte/half/word loads and stores on an internal word array with configurable wait states, and returns ReadData.
//  Raises MemBusy as a stall request to the hazard unit (StallF/StallD/freeze M) while an access is in flight.
// PARAMETERS
//  ADDR_W       8   word-address width; array holds 2**ADDR_W 32-bit words
//  WAIT_STATES  1   extra busy cycles per access (0..15)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  MemReadM   in   1   load request from MEM stage
//  MemWriteM  in   1   store request from MEM stage (MemReadM&MemWriteM never both 1)
//  Funct3M    in   3   access size/sign (RV32I load/store funct3)
//  DataAdr    in   32  byte address (ALUResultM)
//  WriteData  in   32  store data, right-aligned
//  ReadData   out  32  load result, extended to 32 bits
//  MemBusy    out  1   stall request; 1 = hold MEM stage and upstream
//  MisalignErr out 1   one-cycle pulse on misaligned access (only with DMEM_MISALIGN_CHECK_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, cnt=0, ReadData=0, MisalignErr=0. Array contents NOT cleared. Reset mid-access
//    abandons it: a pending store is never written.
//  - FSM IDLE/WAIT/DONE:
//    IDLE: req=MemReadM|MemWriteM. On req: MemBusy=1 (combinational, same cycle); latch addr, data, funct3, op.
//      Next state is WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else DONE.
//    WAIT: MemBusy=1; cnt decrements each cycle; at cnt==0 go to DONE.
//    Edge entering DONE: store commits to the array; the load result is registered into ReadData.
//    DONE: MemBusy=0, ReadData valid, inputs ignored (the same request is still presented this cycle and is NOT
//      re-accepted); unconditional next state IDLE.
//  - Latency: MemBusy high for WAIT_STATES+1 cycles; ReadData valid WAIT_STATES+1 cycles after request seen;
//    back-to-back requests each get full latency. ReadData holds its value until the next DONE.
//  - Index = DataAdr[ADDR_W+1:2]; upper address bits ignored (wrap-around aliasing).
//  - Loads: 000 LB and 100 LBU select byte DataAdr[1:0]; 001 LH and 101 LHU select half DataAdr[1]; 010 LW.
//    LB/LH sign-extend, LBU/LHU zero-extend.
//  - Stores: 000 SB writes WriteData[7:0] to byte lane DataAdr[1:0]; 001 SH writes [15:0] to half lane DataAdr[1];
//    010 SW writes all. Other lanes are untouched.
//  - Funct3 011/110/111: load returns 0, store writes nothing, MisalignErr stays 0; FSM timing is unchanged.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned. The store is suppressed,
//    the load returns 0, and MisalignErr=1 for the DONE cycle only.
//  Undefined: offending low address bits are forced to 0 (half/word aligned down), the access proceeds normally,
//    and MisalignErr is tied 0.
// TESTING
//  1 WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> MemBusy 1,1,0 per access; ReadData=0xDEADBEEF in DONE.
//  2 SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
//  3 SH 0x1234 @0x22, then LH @0x22 -> 0x00001234; LW @0x20 -> 0x1234xxxx (low half unchanged).
//  4 CHECK_EN: SW 0x1 @0x31 -> word @0x30 unchanged, MisalignErr pulses once in DONE.
//    Without CHECK_EN -> word @0x30 = 0x1.
//  5 WAIT_STATES=3: LW issued, reset=0 asserted in WAIT -> ReadData=0, MemBusy=0, IDLE next cycle.
//    Issue SW then reset during WAIT -> target word unchanged.
//  6 ADDR_W=8: SW 0xA5A5A5A5 @0x400, then LW @0x000 -> 0xA5A5A5A5 (wrap); request held through DONE accepted once.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
//   Bus between the core's MEM stage and the data-memory controller.
//   master : MEM stage side (drives request, address, store data)
//   slave  : data_mem_ctrl side (returns load data, busy/stall, misalign pulse)
//   Signals:
//     MemReadM    load request
//     MemWriteM   store request
//     Funct3M     RV32I load/store funct3 (size/sign)
//     DataAdr     byte address
//     WriteData   store data, right-aligned
//     ReadData    load result, extended to 32 bits
//     MemBusy     stall request to the hazard unit
//     MisalignErr one-cycle misaligned-access pulse
interface data_mem_ctrl_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemBusy;
  logic        MisalignErr;

  modport master (
    output MemReadM, MemWriteM, Funct3M, DataAdr, WriteData,
    input  ReadData, MemBusy, MisalignErr
  );

  modport slave (
    input  MemReadM, MemWriteM, Funct3M, DataAdr, WriteData,
    output ReadData, MemBusy, MisalignErr
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data-memory stage behind the core's MEM stage. Performs byte/half/word
//   loads and stores on an internal word array with WAIT_STATES extra busy
//   cycles per access, and raises MemBusy as a stall request while an access
//   is in flight.
//   Parameters:
//     ADDR_W       word-address width (array of 2**ADDR_W 32-bit words)
//     WAIT_STATES  extra busy cycles per access (0..15)
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    data_mem_ctrl_if.slave (request in, ReadData/MemBusy/MisalignErr out)
//   Build option:
//     DMEM_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//     suppressed (load returns 0, no store) and MisalignErr pulses in DONE.
//     When undefined, the offending low address bits are cleared and the
//     access proceeds; MisalignErr is tied 0.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for a request; a request is latched and MemBusy=1
//   S_WAIT | wait states running, cnt counts down to 0
//   S_DONE | access completed, ReadData valid, inputs ignored
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W+1:0]   r_adr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_funct3;
  logic                r_is_store;
  logic [31:0]         r_rdata;
  logic                r_misalign;
  logic [31:0]         r_mem [2**ADDR_W];

  state_t              w_next_state;
  logic                w_req;
  logic                w_busy;
  logic                w_latch;
  logic                w_enter_done;
  logic                w_commit;

  logic [ADDR_W+1:0]   w_acc_adr;
  logic [31:0]         w_acc_wdata;
  logic [2:0]          w_acc_f3;
  logic                w_acc_store;
  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_size;
  logic                w_valid;
  logic                w_mis;
  logic [1:0]          w_off;
  logic [31:0]         w_word;
  logic [31:0]         w_shifted;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wword;
  logic                w_unused;

  assign w_req    = bus.MemReadM | bus.MemWriteM;
  assign w_unused = ^bus.DataAdr[31:ADDR_W+2];

  // With zero wait states the commit happens on the edge leaving IDLE, before
  // anything is latched, so the access fields come straight from the bus there.
  assign w_acc_adr   = (r_state == S_IDLE) ? bus.DataAdr[ADDR_W+1:0] : r_adr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.WriteData : r_wdata;
  assign w_acc_f3    = (r_state == S_IDLE) ? bus.Funct3M : r_funct3;
  assign w_acc_store = (r_state == S_IDLE) ? bus.MemWriteM : r_is_store;

  assign w_idx   = w_acc_adr[ADDR_W+1:2];
  assign w_size  = w_acc_f3[1:0];
  // 011, 110 and 111 are not legal accesses: no data, no store, no error.
  assign w_valid = (w_size != 2'b11) && (w_acc_f3 != 3'b110);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_mis = w_valid && (((w_size == 2'b01) && w_acc_adr[0]) ||
                             ((w_size == 2'b10) && (w_acc_adr[1:0] != 2'b00)));
  assign w_off = w_acc_adr[1:0];
`else
  assign w_mis = 1'b0;
  assign w_off = (w_size == 2'b10) ? 2'b00 :
                 (w_size == 2'b01) ? {w_acc_adr[1], 1'b0} : w_acc_adr[1:0];
`endif

  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_off, 3'b000};

  always_comb begin
    w_load = 32'd0;
    if (w_valid && !w_mis) begin
      case (w_size)
        2'b00:   w_load = w_acc_f3[2] ? {24'd0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
        2'b01:   w_load = w_acc_f3[2] ? {16'd0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
        2'b10:   w_load = w_word;
        default: w_load = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wword = w_acc_wdata;
    if (w_valid && !w_mis) begin
      case (w_size)
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wword = {4{w_acc_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_off;
          w_wword = {2{w_acc_wdata[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b1111;
          w_wword = w_acc_wdata;
        end
        default: w_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_latch      = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_busy  = 1'b1;
          w_latch = 1'b1;
          if (WAIT_STATES > 0) begin
            w_next_state = S_WAIT;
          end else begin
            w_next_state = S_DONE;
            w_enter_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next_state = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The array has no reset, so the write must be blocked explicitly while
  // reset is held; an abandoned store never lands.
  assign w_commit = w_enter_done && reset && w_acc_store;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_adr      <= '0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_is_store <= 1'b0;
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_cnt      <= CNT_LOAD;
        r_adr      <= bus.DataAdr[ADDR_W+1:0];
        r_wdata    <= bus.WriteData;
        r_funct3   <= bus.Funct3M;
        r_is_store <= bus.MemWriteM;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_misalign <= w_enter_done && w_mis;
      if (w_enter_done && !w_acc_store) begin
        r_rdata <= w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign bus.MemBusy     = w_busy;
  assign bus.ReadData    = r_rdata;
  assign bus.MisalignErr = r_misalign;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  localparam int WS = 1;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset3 = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus();
  data_mem_ctrl_if bus3();

  data_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  data_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset3), .bus(bus3.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [1024];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] adr,
                      input logic [31:0] wd, input logic c, input logic [31:0] e, input logic m);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.adr = adr; v.wd = wd;
    v.chk_rd = c; v.exp_rd = e; v.exp_mis = m;
    vecs.push_back(v);
  endtask

  // One complete access on the WS=1 instance; the request stays on the bus
  // through DONE and the following clock edge, then is dropped.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] adr,
                        input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_mis, input string tag);
    @(negedge clk);
    bus.MemReadM = rd; bus.MemWriteM = wr; bus.Funct3M = f3;
    bus.DataAdr = adr; bus.WriteData = wd;
    #1 chk({tag, " busy_req"}, {31'd0, bus.MemBusy}, 32'd1);
    for (int i = 0; i < WS; i++) begin
      @(negedge clk);
      chk({tag, " busy_wait"}, {31'd0, bus.MemBusy}, 32'd1);
    end
    @(negedge clk);
    chk({tag, " busy_done"}, {31'd0, bus.MemBusy}, 32'd0);
    if (chk_rd) chk({tag, " rdata"}, bus.ReadData, exp_rd);
    chk({tag, " mis_done"}, {31'd0, bus.MisalignErr}, {31'd0, exp_mis});
    @(posedge clk);
    #1 bus.MemReadM = 1'b0; bus.MemWriteM = 1'b0;
    @(negedge clk);
    chk({tag, " busy_after"}, {31'd0, bus.MemBusy}, 32'd0);
    chk({tag, " mis_after"}, {31'd0, bus.MisalignErr}, 32'd0);
  endtask

  task automatic access3(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                         input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    @(negedge clk);
    bus3.MemReadM = rd; bus3.MemWriteM = wr; bus3.Funct3M = 3'b010;
    bus3.DataAdr = adr; bus3.WriteData = wd;
    #1 chk({tag, " busy_req"}, {31'd0, bus3.MemBusy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s busy_c%0d", tag, i), {31'd0, bus3.MemBusy}, (i < 4) ? 32'd1 : 32'd0);
    end
    if (chk_rd) chk({tag, " rdata"}, bus3.ReadData, exp_rd);
    @(posedge clk);
    #1 bus3.MemReadM = 1'b0; bus3.MemWriteM = 1'b0;
  endtask

  function automatic int nbytes(input logic [2:0] f3, input bit store);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return store ? 0 : 1;
      3'd5:    return store ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_mis(input int n, input logic [31:0] adr);
    return (n > 1) && ((int'(adr[1:0]) % n) != 0);
  endfunction

  function automatic int base_of(input int n, input logic [31:0] adr);
    int a = int'(adr[9:0]);
    if (n > 1) a = a - (a % n);
    return a;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] adr);
    int n = nbytes(f3, 1'b0);
    int a;
    logic [31:0] v = 32'd0;
    if (n == 0 || (CHK && is_mis(n, adr))) return 32'd0;
    a = base_of(n, adr);
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[a + k];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] wd);
    int n = nbytes(f3, 1'b1);
    int a;
    if (n == 0 || (CHK && is_mis(n, adr))) return;
    a = base_of(n, adr);
    for (int k = 0; k < n; k++) mb[a + k] = wd[8*k +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] adr, wd, exp;
    logic        st, em;
    int          n;

    bus.MemReadM = 0; bus.MemWriteM = 0; bus.Funct3M = 0; bus.DataAdr = 0; bus.WriteData = 0;
    bus3.MemReadM = 0; bus3.MemWriteM = 0; bus3.Funct3M = 0; bus3.DataAdr = 0; bus3.WriteData = 0;

    // directed vectors: rd, wr, f3, adr, wd, check ReadData, expected, expected MisalignErr
    addv(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    addv(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    addv(0, 1, 3'd2, 32'h10, 32'h0, 0, 0, 0);
    addv(0, 1, 3'd0, 32'h13, 32'h12345680, 0, 0, 0);
    addv(1, 0, 3'd0, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0);
    addv(1, 0, 3'd4, 32'h13, 32'h0, 1, 32'h00000080, 0);
    addv(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h80000000, 0);
    addv(0, 1, 3'd2, 32'h20, 32'h55667788, 0, 0, 0);
    addv(0, 1, 3'd1, 32'h22, 32'hABCD1234, 0, 0, 0);
    addv(1, 0, 3'd1, 32'h22, 32'h0, 1, 32'h00001234, 0);
    addv(1, 0, 3'd2, 32'h20, 32'h0, 1, 32'h12347788, 0);
    addv(0, 1, 3'd1, 32'h20, 32'hFFFF8001, 0, 0, 0);
    addv(1, 0, 3'd1, 32'h20, 32'h0, 1, 32'hFFFF8001, 0);
    addv(1, 0, 3'd5, 32'h20, 32'h0, 1, 32'h00008001, 0);
    addv(1, 0, 3'd0, 32'h21, 32'h0, 1, 32'hFFFFFF80, 0);
    addv(1, 0, 3'd4, 32'h20, 32'h0, 1, 32'h00000001, 0);
    addv(1, 0, 3'd2, 32'h20, 32'h0, 1, 32'h12348001, 0);
    addv(0, 1, 3'd2, 32'h30, 32'h0, 0, 0, 0);
    addv(0, 1, 3'd2, 32'h31, 32'h1, 0, 0, CHK);
    addv(1, 0, 3'd2, 32'h30, 32'h0, 1, CHK ? 32'h0 : 32'h1, 0);
    addv(1, 0, 3'd2, 32'h31, 32'h0, 1, CHK ? 32'h0 : 32'h1, CHK);
    addv(0, 1, 3'd2, 32'h400, 32'hA5A5A5A5, 0, 0, 0);
    addv(1, 0, 3'd2, 32'h000, 32'h0, 1, 32'hA5A5A5A5, 0);
    addv(1, 0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 0);
    addv(0, 1, 3'd7, 32'h10, 32'hFFFFFFFF, 0, 0, 0);
    addv(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h80000000, 0);
    addv(1, 0, 3'd6, 32'h10, 32'h0, 1, 32'h0, 0);

    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, bus.MemBusy}, 32'd0);
    chk("reset rdata", bus.ReadData, 32'd0);
    chk("reset mis", {31'd0, bus.MisalignErr}, 32'd0);
    chk("reset3 rdata", bus3.ReadData, 32'd0);
    chk("reset3 busy", {31'd0, bus3.MemBusy}, 32'd0);
    reset = 1'b1;
    reset3 = 1'b1;

    foreach (vecs[i])
      access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].adr, vecs[i].wd,
             vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_mis, $sformatf("vec%0d", i));

    // randomized traffic in words 64..79 with random upper address bits
    for (int i = 64; i < 80; i++) begin
      wd = $urandom();
      adr = $urandom();
      adr[9:0] = 10'(i * 4);
      m_store(3'd2, adr, wd);
      access(0, 1, 3'd2, adr, wd, 0, 0, 0, "init");
    end
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      adr = $urandom();
      adr[9:2] = 8'($urandom_range(64, 79));
      wd = $urandom();
      n = nbytes(f3, st);
      em = CHK && is_mis(n, adr);
      exp = 32'd0;
      if (st) m_store(f3, adr, wd);
      else exp = m_load(f3, adr);
      access(!st, st, f3, adr, wd, !st, exp, em, $sformatf("rnd%0d", t));
    end

    // WAIT_STATES=3 instance: latency and reset during WAIT
    access3(0, 1, 32'h40, 32'h11111111, 0, 0, "ws3_sw");
    access3(1, 0, 32'h40, 32'h0, 1, 32'h11111111, "ws3_lw");

    @(negedge clk);
    bus3.MemReadM = 1; bus3.Funct3M = 3'b010; bus3.DataAdr = 32'h40;
    @(negedge clk);
    chk("rst_lw busy_wait", {31'd0, bus3.MemBusy}, 32'd1);
    chk("rst_lw rdata_hold", bus3.ReadData, 32'h11111111);
    reset3 = 1'b0; bus3.MemReadM = 0;
    #1;
    chk("rst_lw rdata", bus3.ReadData, 32'd0);
    chk("rst_lw busy", {31'd0, bus3.MemBusy}, 32'd0);
    chk("rst_lw mis", {31'd0, bus3.MisalignErr}, 32'd0);
    @(negedge clk);
    reset3 = 1'b1;
    @(negedge clk);
    chk("rst_lw idle_busy", {31'd0, bus3.MemBusy}, 32'd0);

    @(negedge clk);
    bus3.MemWriteM = 1; bus3.Funct3M = 3'b010; bus3.DataAdr = 32'h40; bus3.WriteData = 32'h22222222;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sw busy_wait", {31'd0, bus3.MemBusy}, 32'd1);
    reset3 = 1'b0; bus3.MemWriteM = 0;
    repeat (2) @(negedge clk);
    reset3 = 1'b1;
    access3(1, 0, 32'h40, 32'h0, 1, 32'h11111111, "rst_sw check");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
